// File: rtl/pc_fetch_register.sv
// Program counter register with next-PC select, stall-time redirect buffering
// and a sticky trap on misaligned branch/jump targets.
module pc_fetch_register #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          COUNT_WIDTH  = 32
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Stall,
    input  logic [31:0]            PCAddResult,
    input  logic                   BranchTaken,
    input  logic [31:0]            BranchTarget,
    input  logic                   Jump,
    input  logic [31:0]            JumpTarget,
    output logic [31:0]            PCResult,
    output logic                   FetchValid,
    output logic                   RedirectPending,
    output logic                   Misaligned,
    output logic [COUNT_WIDTH-1:0] FetchCount
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state;
    logic [31:0] pend_tgt;
    logic [31:0] new_tgt;
    logic        new_redir;
    logic [31:0] sel_pc;
    logic        sel_redir;
    logic        sel_bad;

    // Fresh redirect this cycle: jump beats branch.
    always_comb begin
        new_redir = Jump | BranchTaken;
        new_tgt   = Jump ? JumpTarget : BranchTarget;
    end

    // Pending redirect sits between fresh redirects and the adder; only
    // redirect targets are alignment-checked, the adder output is trusted.
    always_comb begin
        sel_pc    = PCAddResult;
        sel_redir = 1'b0;
        if (new_redir) begin
            sel_pc    = new_tgt;
            sel_redir = 1'b1;
        end else if (RedirectPending) begin
            sel_pc    = pend_tgt;
            sel_redir = 1'b1;
        end
        sel_bad = sel_redir && (sel_pc[1:0] != 2'b00);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state           <= BOOT;
            PCResult        <= RESET_VECTOR;
            FetchValid      <= 1'b0;
            RedirectPending <= 1'b0;
            Misaligned      <= 1'b0;
            FetchCount      <= '0;
            pend_tgt        <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state      <= RUN;
                    FetchValid <= 1'b1;
                end
                RUN: begin
                    if (Stall) begin
                        // Latest stalled redirect overwrites any older one.
                        if (new_redir) begin
                            pend_tgt        <= new_tgt;
                            RedirectPending <= 1'b1;
                        end
                    end else begin
                        RedirectPending <= 1'b0;
                        PCResult        <= sel_pc;
                        if (sel_bad) begin
                            state      <= HALT;
                            Misaligned <= 1'b1;
                            FetchValid <= 1'b0;
                        end else begin
                            FetchCount <= FetchCount + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state      <= HALT;
                    FetchValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_register.sv
// Directed bench for pc_fetch_register: sequential fetch, redirect priority,
// stall buffering, misalignment trap, async reset and counter wrap.
module tb_pc_fetch_register;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic        FetchValid;
    logic        RedirectPending;
    logic        Misaligned;
    logic [31:0] FetchCount;

    // Narrow-counter instance for the wrap check.
    logic        rst2;
    logic [31:0] pc2;
    logic [31:0] pc2_add;
    logic        fv2, rp2, mis2;
    logic [3:0]  cnt2;

    int n_chk = 0;
    int n_err = 0;

    assign PCAddResult = PCResult + 32'd4;
    assign pc2_add     = pc2 + 32'd4;

    pc_fetch_register dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .PCAddResult(PCAddResult),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget), .PCResult(PCResult),
        .FetchValid(FetchValid), .RedirectPending(RedirectPending),
        .Misaligned(Misaligned), .FetchCount(FetchCount)
    );

    pc_fetch_register #(.COUNT_WIDTH(4)) dut4 (
        .Clk(Clk), .Reset(rst2), .Stall(1'b0), .PCAddResult(pc2_add),
        .BranchTaken(1'b0), .BranchTarget(32'h0), .Jump(1'b0), .JumpTarget(32'h0),
        .PCResult(pc2), .FetchValid(fv2), .RedirectPending(rp2),
        .Misaligned(mis2), .FetchCount(cnt2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic st(input string tag, input logic [31:0] pc, input logic fv,
                      input logic rp, input logic mis, input logic [31:0] cnt);
        chk({tag, ".pc"},  PCResult, pc);
        chk({tag, ".fv"},  {31'b0, FetchValid}, {31'b0, fv});
        chk({tag, ".rp"},  {31'b0, RedirectPending}, {31'b0, rp});
        chk({tag, ".mis"}, {31'b0, Misaligned}, {31'b0, mis});
        chk({tag, ".cnt"}, FetchCount, cnt);
    endtask

    initial begin
        Reset = 1'b0; rst2 = 1'b0; Stall = 1'b0;
        BranchTaken = 1'b0; BranchTarget = '0; Jump = 1'b0; JumpTarget = '0;
        #3;
        st("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        Reset = 1'b1;
        st("boot", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(); st("run0", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
        step(); st("run4", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1);
        step(); st("run8", 32'h8, 1'b1, 1'b0, 1'b0, 32'd2);
        step(); st("run12", 32'hC, 1'b1, 1'b0, 1'b0, 32'd3);

        // Jump and branch together: jump wins.
        BranchTaken = 1'b1; BranchTarget = 32'h40; Jump = 1'b1; JumpTarget = 32'h100;
        step(); st("prio", 32'h100, 1'b1, 1'b0, 1'b0, 32'd4);
        BranchTaken = 1'b0; Jump = 1'b0;
        step(); st("seq", 32'h104, 1'b1, 1'b0, 1'b0, 32'd5);

        // Three-cycle stall with branch then jump buffered.
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h80;
        step(); st("stall1", 32'h104, 1'b1, 1'b1, 1'b0, 32'd5);
        BranchTaken = 1'b0; Jump = 1'b1; JumpTarget = 32'h200;
        step(); st("stall2", 32'h104, 1'b1, 1'b1, 1'b0, 32'd5);
        Jump = 1'b0;
        step(); st("stall3", 32'h104, 1'b1, 1'b1, 1'b0, 32'd5);
        Stall = 1'b0;
        step(); st("unstall", 32'h200, 1'b1, 1'b0, 1'b0, 32'd6);

        // Fresh branch beats a queued pending target; pending still clears.
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h80;
        step(); st("q80", 32'h200, 1'b1, 1'b1, 1'b0, 32'd6);
        Stall = 1'b0; BranchTarget = 32'h300;
        step(); st("newwin", 32'h300, 1'b1, 1'b0, 1'b0, 32'd7);
        BranchTaken = 1'b0;
        step(); st("pclr", 32'h304, 1'b1, 1'b0, 1'b0, 32'd8);

        // Pending target alone is taken once the stall lifts.
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h80;
        step();
        Stall = 1'b0; BranchTaken = 1'b0;
        step(); st("pend", 32'h80, 1'b1, 1'b0, 1'b0, 32'd9);

        // Misaligned jump traps; nothing afterward moves the PC.
        Jump = 1'b1; JumpTarget = 32'h102;
        step(); st("trap", 32'h102, 1'b0, 1'b0, 1'b1, 32'd9);
        JumpTarget = 32'h400; Stall = 1'b1;
        step();
        Stall = 1'b0; Jump = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h500;
        step(); st("halt", 32'h102, 1'b0, 1'b0, 1'b1, 32'd9);
        BranchTaken = 1'b0;

        // Async reset mid-cycle.
        #2 Reset = 1'b0;
        #1 st("areset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        Reset = 1'b1;
        step(); st("reboot", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);

        // Misaligned pending target traps when it is selected.
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h81;
        step(); st("qbad", 32'h0, 1'b1, 1'b1, 1'b0, 32'd0);
        Stall = 1'b0; BranchTaken = 1'b0;
        step(); st("ptrap", 32'h81, 1'b0, 1'b0, 1'b1, 32'd0);

        // 4-bit counter wraps after 16 fetches.
        rst2 = 1'b1;
        step();
        repeat (15) step();
        chk("cnt4.15", {28'b0, cnt2}, 32'd15);
        chk("pc4.15", pc2, 32'd60);
        step();
        chk("cnt4.wrap", {28'b0, cnt2}, 32'd0);
        chk("pc4.16", pc2, 32'd64);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
